// File: rtl/mem_data_mux_if.sv
// Bus bundle for mem_data_mux: the two binary source channels, the dual-rail
// NCL data bus toward mem_data_demux, its completion acknowledge and status.
interface mem_data_mux_if #(
  parameter int W = 8
);
  // instruction source
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         i_ready;
  // constant source
  logic [W-1:0] c_data;
  logic         c_valid;
  logic         c_ready;
  // dual-rail bus and phase bit (NULL = both rails 0)
  logic [W-1:0] D_t;
  logic [W-1:0] D_f;
  logic         PH0_t;
  logic         PH0_f;
  // receiver completion, asynchronous to clk
  logic         ack;
  // status
  logic         busy;
  logic         proto_err;

  // the transmitter side
  modport master (
    input  i_data, i_valid, c_data, c_valid, ack,
    output i_ready, c_ready, D_t, D_f, PH0_t, PH0_f, busy, proto_err
  );

  // the sources plus the receiver, as seen from outside the transmitter
  modport slave (
    output i_data, i_valid, c_data, c_valid, ack,
    input  i_ready, c_ready, D_t, D_f, PH0_t, PH0_f, busy, proto_err
  );
endinterface

// File: rtl/mem_data_mux.sv
// Clocked dual-rail transmitter: arbitrates the I and C word sources, sends
// each accepted word as a DATA wavefront (PH0 names the channel) and runs the
// four-phase DATA/NULL handshake against a synchronized completion ack.
module mem_data_mux #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input logic             clk,
  input logic             rst_n,
  mem_data_mux_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_NUL  = 2'd2
  } state_e;

  state_e                 r_state;
  state_e                 w_next_state;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;

  // latched word and its channel (0 = I, 1 = C)
  logic [W-1:0]           r_word;
  logic                   r_chan;
  logic                   r_last_c;     // 1 = C served last

  // registered outputs
  logic [W-1:0]           r_d_t, r_d_f;
  logic                   r_ph0_t, r_ph0_f;
  logic                   r_i_ready, r_c_ready;
  logic                   r_busy, r_proto_err;

  // next values of the above
  logic                   w_accept, w_win_c;
  logic [W-1:0]           w_word;
  logic                   w_chan;
  logic [W-1:0]           w_d_t, w_d_f;
  logic                   w_ph0_t, w_ph0_f;
  logic                   w_i_ready, w_c_ready;
  logic                   w_busy, w_proto_err;

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // Synchronize the asynchronous completion ack into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= '0;
    end else begin
      // NOTE: state is updated with <= so every flop samples pre-edge values;
      // blocking here would collapse the synchronizer chain into one flop.
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack};
    end
  end

  // Pick the winner: a lone valid wins, a tie goes to the channel not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_win_c = bus.c_valid;
    if (bus.i_valid && bus.c_valid) begin
      w_win_c = ~r_last_c;
    end
  end

  assign w_accept = (r_state == ST_IDLE) && !w_ack_s && (bus.i_valid || bus.c_valid);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: IDLE -> DATA on acceptance, DATA -> NUL on ack_s, NUL -> IDLE on !ack_s.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_DATA;
      ST_DATA: if (w_ack_s)  w_next_state = ST_NUL;
      ST_NUL:  if (!w_ack_s) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // bus flops line up with the state flops.
  always_comb begin
    w_word      = w_accept ? (w_win_c ? bus.c_data : bus.i_data) : r_word;
    w_chan      = w_accept ? w_win_c : r_chan;
    w_d_t       = '0;
    w_d_f       = '0;
    w_ph0_t     = 1'b0;
    w_ph0_f     = 1'b0;
    if (w_next_state == ST_DATA) begin
      w_d_t   = w_word;
      w_d_f   = ~w_word;
      w_ph0_t = w_chan;
      w_ph0_f = ~w_chan;
    end
    w_i_ready   = w_accept && !w_win_c;
    w_c_ready   = w_accept && w_win_c;
    w_busy      = (w_next_state != ST_IDLE);
    w_proto_err = r_proto_err || ((r_state == ST_IDLE) && w_ack_s);
  end

  // Word/channel hold, round-robin history and all output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the word holder is a single register, not a memory array, so it
      // is cleared with everything else and never shows X after reset.
      r_word      <= '0;
      r_chan      <= 1'b0;
      r_last_c    <= 1'b1;
      r_d_t       <= '0;
      r_d_f       <= '0;
      r_ph0_t     <= 1'b0;
      r_ph0_f     <= 1'b0;
      r_i_ready   <= 1'b0;
      r_c_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_word      <= w_word;
      r_chan      <= w_chan;
      if (w_accept) r_last_c <= w_win_c;
      r_d_t       <= w_d_t;
      r_d_f       <= w_d_f;
      r_ph0_t     <= w_ph0_t;
      r_ph0_f     <= w_ph0_f;
      r_i_ready   <= w_i_ready;
      r_c_ready   <= w_c_ready;
      r_busy      <= w_busy;
      r_proto_err <= w_proto_err;
    end
  end

  assign bus.D_t       = r_d_t;
  assign bus.D_f       = r_d_f;
  assign bus.PH0_t     = r_ph0_t;
  assign bus.PH0_f     = r_ph0_f;
  assign bus.i_ready   = r_i_ready;
  assign bus.c_ready   = r_c_ready;
  assign bus.busy      = r_busy;
  assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_data_mux.sv
// Self-checking bench for mem_data_mux: directed sequences with literal
// expectations plus a per-cycle scoreboard of the words that must appear.
module tb_mem_data_mux;

  localparam int W  = 8;
  localparam int SS = 2;

  typedef struct packed {
    logic         ch;    // 0 = I, 1 = C
    logic [W-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ack_auto;
  logic man_ack;
  logic exp_perr;
  logic perr_window;
  int   checks = 0;
  int   errors = 0;

  word_t        sb[$];
  logic         prev_data;
  logic [W:0]   prev_word;

  mem_data_mux_if #(.W(W)) bus ();

  mem_data_mux #(.W(W), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // receiver model: completion is the OR of every rail (zero-delay loop)
  assign bus.ack = ack_auto ? ((|(bus.D_t | bus.D_f)) | bus.PH0_t | bus.PH0_f) : man_ack;

  wire w_null = (bus.D_t == '0) && (bus.D_f == '0) && !bus.PH0_t && !bus.PH0_f;
  wire w_data = ((bus.D_t ^ bus.D_f) == '1) && (bus.PH0_t ^ bus.PH0_f);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (bus.busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", bus.busy, 0);
  endtask

  // Per-cycle compare against the scoreboard and the bus-legality rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_data <= 1'b0;
      prev_word <= '0;
    end else begin
      check("rail_excl", {bus.PH0_t & bus.PH0_f, bus.D_t & bus.D_f}, 0);
      check("bus_legal", w_null || w_data, 1);
      if (w_data && !prev_data) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          check("word_t",  bus.D_t,   sb[0].data);
          check("word_f",  bus.D_f,   sb[0].data ^ 8'hFF);
          check("ph0_t",   bus.PH0_t, sb[0].ch);
          check("ph0_f",   bus.PH0_f, sb[0].ch ^ 1'b1);
          check("ready_onset", {bus.i_ready, bus.c_ready}, sb[0].ch ? 2'b01 : 2'b10);
          void'(sb.pop_front());
        end
      end else begin
        check("ready_idle", {bus.i_ready, bus.c_ready}, 0);
      end
      if (w_data && prev_data) check("data_hold", {bus.PH0_t, bus.D_t}, prev_word);
      if (w_data) check("busy_in_data", bus.busy, 1);
      if (!perr_window) check("proto_err", bus.proto_err, exp_perr);
      prev_data <= w_data;
      prev_word <= {bus.PH0_t, bus.D_t};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] i_words [2];
    logic [W-1:0] c_words [2];
    int ii, ci, n, ip, cp, bad, rp;

    i_words[0] = 8'h11; i_words[1] = 8'h22;
    c_words[0] = 8'h33; c_words[1] = 8'h44;

    rst_n = 1'b0; ack_auto = 1'b0; man_ack = 1'b0;
    exp_perr = 1'b0; perr_window = 1'b0;
    bus.i_data = '0; bus.i_valid = 1'b0; bus.c_data = '0; bus.c_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_dt",    bus.D_t, 0);
    check("rst_df",    bus.D_f, 0);
    check("rst_ph0",   {bus.PH0_t, bus.PH0_f}, 0);
    check("rst_ready", {bus.i_ready, bus.c_ready}, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_perr",  bus.proto_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a DATA wavefront (ack held low)
    sb.push_back('{ch: 1'b0, data: 8'hA5});
    bus.i_data = 8'hA5; bus.i_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_dt", bus.D_t, 8'hA5);
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus",   {bus.D_t, bus.D_f}, 0);
    check("mid_rst_ph0",   {bus.PH0_t, bus.PH0_f}, 0);
    check("mid_rst_ready", {bus.i_ready, bus.c_ready}, 0);
    check("mid_rst_busy",  bus.busy, 0);
    check("mid_rst_perr",  bus.proto_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // round-robin with both sources always valid: I, C, I, C
    ack_auto = 1'b1;
    sb.push_back('{ch: 1'b0, data: 8'h11});
    sb.push_back('{ch: 1'b1, data: 8'h33});
    sb.push_back('{ch: 1'b0, data: 8'h22});
    sb.push_back('{ch: 1'b1, data: 8'h44});
    bus.i_data = i_words[0]; bus.c_data = c_words[0];
    bus.i_valid = 1'b1; bus.c_valid = 1'b1;
    ii = 0; ci = 0; n = 0;
    while ((ii < 2 || ci < 2) && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.i_ready) begin
        ii++;
        if (ii < 2) bus.i_data = i_words[ii]; else begin bus.i_valid = 1'b0; bus.i_data = 8'hEE; end
      end
      if (bus.c_ready) begin
        ci++;
        if (ci < 2) bus.c_data = c_words[ci]; else begin bus.c_valid = 1'b0; bus.c_data = 8'hDD; end
      end
    end
    check("rr_i_count", ii, 2);
    check("rr_c_count", ci, 2);
    wait_idle(20);
    check("rr_sb_empty", sb.size(), 0);
    @(negedge clk);

    // single I word with exact latencies
    sb.push_back('{ch: 1'b0, data: 8'h3C});
    bus.i_data = 8'h3C; bus.i_valid = 1'b1;
    @(negedge clk);
    check("i_ready", bus.i_ready, 1);
    check("i_dt",    bus.D_t, 8'h3C);
    check("i_df",    bus.D_f, 8'hC3);
    check("i_ph0",   {bus.PH0_t, bus.PH0_f}, 2'b01);
    bus.i_valid = 1'b0; bus.i_data = 8'h00;
    repeat (2) @(negedge clk);
    check("i_data_held", bus.D_t, 8'h3C);
    @(negedge clk);
    check("i_null_at_s1", {bus.D_t, bus.D_f, bus.PH0_t, bus.PH0_f}, 0);
    check("i_busy_nul", bus.busy, 1);
    repeat (2) @(negedge clk);
    check("i_busy_before_idle", bus.busy, 1);
    @(negedge clk);
    check("i_idle_at_s1", bus.busy, 0);

    // single C word; I must never be acknowledged
    sb.push_back('{ch: 1'b1, data: 8'hFF});
    bus.c_data = 8'hFF; bus.c_valid = 1'b1;
    @(negedge clk);
    check("c_ready", bus.c_ready, 1);
    check("c_dt",    bus.D_t, 8'hFF);
    check("c_df",    bus.D_f, 8'h00);
    check("c_ph0",   {bus.PH0_t, bus.PH0_f}, 2'b10);
    bus.c_valid = 1'b0;
    ip = 0; cp = 1;
    repeat (8) begin
      @(negedge clk);
      if (bus.i_ready) ip++;
      if (bus.c_ready) cp++;
    end
    check("c_no_i_ready", ip, 0);
    check("c_one_pulse",  cp, 1);
    wait_idle(20);

    // stalled ack: DATA must hold for 50 cycles
    ack_auto = 1'b0; man_ack = 1'b0;
    sb.push_back('{ch: 1'b0, data: 8'h5A});
    bus.i_data = 8'h5A; bus.i_valid = 1'b1;
    @(negedge clk);
    check("stall_ready", bus.i_ready, 1);
    bus.i_valid = 1'b0; bus.i_data = 8'h00;
    bad = 0; rp = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.D_t !== 8'h5A || bus.busy !== 1'b1) bad++;
      if (bus.i_ready || bus.c_ready) rp++;
    end
    check("stall_stable",   bad, 0);
    check("stall_no_ready", rp, 0);
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_sync_hold", bus.D_t, 8'h5A);
    @(negedge clk);
    check("stall_null", {bus.D_t, bus.D_f, bus.PH0_t, bus.PH0_f}, 0);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stall_busy_hold", bus.busy, 1);
    @(negedge clk);
    check("stall_idle", bus.busy, 0);

    // protocol error: ack high while IDLE
    perr_window = 1'b1;
    man_ack = 1'b1;
    repeat (SS + 1) @(negedge clk);
    check("perr_set", bus.proto_err, 1);
    exp_perr = 1'b1; perr_window = 1'b0;
    bus.i_data = 8'h77; bus.i_valid = 1'b1;
    repeat (6) @(negedge clk);
    check("perr_no_accept", bus.busy, 0);
    sb.push_back('{ch: 1'b0, data: 8'h77});
    ack_auto = 1'b1;
    n = 0;
    while (!bus.i_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("perr_accept", bus.i_ready, 1);
    bus.i_valid = 1'b0;
    wait_idle(20);
    check("perr_sticky", bus.proto_err, 1);

    // reset clears the sticky error
    @(negedge clk);
    exp_perr = 1'b0;
    rst_n = 1'b0;
    #1;
    check("perr_cleared", bus.proto_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
